// File: rtl/ahb_bram_pkg.sv
// Shared AHB-Lite codes, controller FSM encoding and address constants
// for the AHB block-RAM controller.
package ahb_bram_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] SIZE_BYTE = 3'd0;
  localparam logic [2:0] SIZE_HALF = 3'd1;
  localparam logic [2:0] SIZE_WORD = 3'd2;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_STALL,
    ST_ERR1,
    ST_ERR2
  } state_e;

  // Byte address bits below this position select a byte within a 32-bit word.
  localparam int WORD_OFFSET = 2;

endpackage

// File: rtl/ahb_bram_ctrl_if.sv
// AHB-Lite slave bus plus simple dual-port BRAM connection for ahb_bram_ctrl.
interface ahb_bram_ctrl_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  HSEL;
  logic [31:0]           HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [31:0]           HWDATA;
  logic                  HREADY;
  logic                  HREADYOUT;
  logic                  HRESP;
  logic [31:0]           HRDATA;
  logic [ADDR_WIDTH-1:0] bram_addra;
  logic [31:0]           bram_dina;
  logic [3:0]            bram_wea;
  logic [ADDR_WIDTH-1:0] bram_addrb;
  logic [31:0]           bram_doutb;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY, bram_doutb,
    output HREADYOUT, HRESP, HRDATA, bram_addra, bram_dina, bram_wea, bram_addrb
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY, bram_doutb,
    input  HREADYOUT, HRESP, HRDATA, bram_addra, bram_dina, bram_wea, bram_addrb
  );

endinterface

// File: rtl/ahb_bram_bytemask.sv
// Decodes AHB transfer size and low address bits into a byte-lane mask,
// flagging unsupported sizes and misaligned accesses as illegal.
module ahb_bram_bytemask
  import ahb_bram_pkg::*;
(
  input  logic [2:0] hsize_i,
  input  logic [1:0] addr_i,
  output logic [3:0] mask_o,
  output logic       illegal_o
);

  // Illegal transfers leave the mask empty so they can never reach the RAM.
  always_comb begin
    mask_o    = 4'b0000;
    illegal_o = 1'b0;
    case (hsize_i)
      SIZE_BYTE: mask_o = 4'b0001 << addr_i;
      SIZE_HALF: begin
        if (addr_i[0]) illegal_o = 1'b1;
        else           mask_o    = addr_i[1] ? 4'b1100 : 4'b0011;
      end
      SIZE_WORD: begin
        if (addr_i != 2'b00) illegal_o = 1'b1;
        else                 mask_o    = 4'b1111;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb_bram_ctrl.sv
// AHB-Lite slave front end for a simple dual-port block RAM with registered read.
// Optional macro BRAM_FWD_EN forwards colliding write data instead of stalling the read.
module ahb_bram_ctrl
  import ahb_bram_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic           HCLK,
  input  logic           HRESETn,
  ahb_bram_ctrl_if.slave bus
);

  logic [ADDR_WIDTH-1:0] addrIdx;
  logic [3:0]            reqMask;
  logic                  reqIllegal;
  logic                  accept, legalAccept, illegalAccept;
  logic                  wrPhase, rdPhase, collision;
  state_e                state_q, state_d;
  logic                  dpValid_q, dpValid_d;
  logic                  dpWrite_q, dpWrite_d;
  logic [ADDR_WIDTH-1:0] dpIdx_q, dpIdx_d;
  logic [3:0]            dpMask_q, dpMask_d;
  logic                  readyOut, respOut;
  logic [ADDR_WIDTH-1:0] rdAddr;
  logic [31:0]           rdData;
  logic                  unusedBits;

  assign addrIdx    = bus.HADDR[ADDR_WIDTH+WORD_OFFSET-1:WORD_OFFSET];
  assign unusedBits = ^{bus.HADDR[31:ADDR_WIDTH+WORD_OFFSET], bus.HTRANS[0]};

  ahb_bram_bytemask uMask (
    .hsize_i   (bus.HSIZE),
    .addr_i    (bus.HADDR[1:0]),
    .mask_o    (reqMask),
    .illegal_o (reqIllegal)
  );

  assign accept        = bus.HSEL & bus.HREADY & bus.HTRANS[1];
  assign legalAccept   = accept & ~reqIllegal;
  assign illegalAccept = accept & reqIllegal;

  assign wrPhase   = dpValid_q & dpWrite_q & (state_q == ST_IDLE);
  assign rdPhase   = dpValid_q & ~dpWrite_q & (state_q == ST_IDLE);
  // The RAM read port samples before the write commits, so a same-word read sees stale data.
  assign collision = wrPhase & legalAccept & ~bus.HWRITE & (addrIdx == dpIdx_q);

  // Data-phase context only advances when the bus completes a cycle.
  always_comb begin
    dpValid_d = dpValid_q;
    dpWrite_d = dpWrite_q;
    dpIdx_d   = dpIdx_q;
    dpMask_d  = dpMask_q;
    if (bus.HREADY) begin
      dpValid_d = legalAccept;
      dpWrite_d = bus.HWRITE;
      dpIdx_d   = addrIdx;
      dpMask_d  = reqMask;
    end
  end

  always_comb begin
    state_d  = state_q;
    readyOut = 1'b1;
    respOut  = RESP_OKAY;
    rdAddr   = addrIdx;
    case (state_q)
      ST_IDLE: begin
        if (illegalAccept) state_d = ST_ERR1;
`ifndef BRAM_FWD_EN
        else if (collision) state_d = ST_RD_STALL;
`endif
      end
      ST_RD_STALL: begin
        readyOut = 1'b0;
        rdAddr   = dpIdx_q;
        state_d  = ST_IDLE;
      end
      ST_ERR1: begin
        readyOut = 1'b0;
        respOut  = RESP_ERROR;
        state_d  = ST_ERR2;
      end
      ST_ERR2: begin
        respOut = RESP_ERROR;
        state_d = illegalAccept ? ST_ERR1 : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= ST_IDLE;
      dpValid_q <= 1'b0;
      dpWrite_q <= 1'b0;
      dpIdx_q   <= '0;
      dpMask_q  <= 4'b0000;
    end else begin
      state_q   <= state_d;
      dpValid_q <= dpValid_d;
      dpWrite_q <= dpWrite_d;
      dpIdx_q   <= dpIdx_d;
      dpMask_q  <= dpMask_d;
    end
  end

`ifdef BRAM_FWD_EN
  logic [31:0] fwdData_q, fwdData_d;
  logic [3:0]  fwdMask_q, fwdMask_d;

  always_comb begin
    fwdData_d = fwdData_q;
    fwdMask_d = fwdMask_q;
    if (bus.HREADY) begin
      fwdData_d = bus.HWDATA;
      fwdMask_d = collision ? dpMask_q : 4'b0000;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      fwdData_q <= 32'h0;
      fwdMask_q <= 4'b0000;
    end else begin
      fwdData_q <= fwdData_d;
      fwdMask_q <= fwdMask_d;
    end
  end

  // Bytes written by the colliding write override the stale RAM output.
  always_comb begin
    rdData = bus.bram_doutb;
    for (int b = 0; b < 4; b++) begin
      if (fwdMask_q[b]) rdData[8*b +: 8] = fwdData_q[8*b +: 8];
    end
  end
`else
  assign rdData = bus.bram_doutb;
`endif

  assign bus.HREADYOUT  = readyOut;
  assign bus.HRESP      = respOut;
  assign bus.HRDATA     = rdPhase ? rdData : 32'h0;
  assign bus.bram_addra = dpIdx_q;
  assign bus.bram_dina  = bus.HWDATA;
  assign bus.bram_wea   = wrPhase ? dpMask_q : 4'b0000;
  assign bus.bram_addrb = rdAddr;

endmodule

// File: doc/ahb_bram_ctrl.md
Name: ahb_bram_ctrl

Overview:
AHB-Lite slave controller that sequences the simple dual-port block RAM (write port addra/dina/wea, read port addrb/doutb with 1-cycle registered read) as the Cortex-M0 code/data memory. It decodes transfer size to byte strobes and times writes into the data phase. It resolves the read-after-write collision that occurs when a read address phase overlaps a write data phase to the same word. It also returns AHB error responses for illegal transfers.

Parameters:
ADDR_WIDTH, 12, RAM word-address width; the RAM holds 2**ADDR_WIDTH 32-bit words; the word index is HADDR[ADDR_WIDTH+1:2].

Ports:
HCLK  in  1  system clock, the single clock of the block
HRESETn  in  1  asynchronous active-low reset
HSEL  in  1  slave select from the bus decoder
HADDR  in  32  byte address; bits above ADDR_WIDTH+1 are ignored
HTRANS  in  2  transfer type; NONSEQ/SEQ count as active
HWRITE  in  1  1 = write
HSIZE  in  3  0 = byte, 1 = halfword, 2 = word
HWDATA  in  32  write data, valid in the data phase
HREADY  in  1  bus-level ready; address phase is sampled only when high
HREADYOUT  out  1  slave ready
HRESP  out  1  0 = OKAY, 1 = ERROR
HRDATA  out  32  read data
bram_addra  out  ADDR_WIDTH  RAM write word address
bram_dina  out  32  RAM write data
bram_wea  out  4  RAM byte write enables
bram_addrb  out  ADDR_WIDTH  RAM read word address
bram_doutb  in  32  RAM registered read data

Behaviour:
- Transfer accept: HSEL & HREADY & HTRANS[1]. The block registers word index, HWRITE and a 4-bit byte mask on HCLK.
- Byte mask:
  - byte: 1<<HADDR[1:0]
  - halfword: 0011 or 1100 by HADDR[1]
  - word: 1111
- Illegal transfers produce no RAM access and a two-cycle ERROR:
  - HSIZE>2
  - halfword with HADDR[0]=1
  - word with HADDR[1:0]!=0
  - ERROR cycle 1: HREADYOUT=0, HRESP=1. Cycle 2: HREADYOUT=1, HRESP=1.
- Write:
  - The data phase is the cycle after accept.
  - During it, bram_addra = registered index, bram_dina = HWDATA, bram_wea = registered mask. All are combinational from registered state.
  - The RAM commits at the end of that cycle. Zero wait states.
  - bram_wea=0 in every other cycle.
- Read:
  - bram_addrb = HADDR word index combinationally during the address phase, so bram_doutb is valid in the data phase.
  - In the data phase, HRDATA = bram_doutb; otherwise HRDATA = 0. Zero wait states in the normal case.
- Collision: a read accepted in the same cycle as a write data phase to the same word index. The RAM returns old data.
  - Default (without BRAM_FWD_EN): one wait state.
  - FSM states: IDLE, RD_STALL, ERR1, ERR2.
  - IDLE -> RD_STALL on collision. In RD_STALL: HREADYOUT=0, bram_addrb = registered read index. Next cycle returns to IDLE with HREADYOUT=1 and HRDATA = updated bram_doutb.
  - IDLE -> ERR1 on an illegal accept. ERR1 -> ERR2 -> IDLE.
- Different indices, or a write following a write, never stall.
- IDLE/BUSY transfers or HSEL=0: HREADYOUT=1, HRESP=0, no RAM writes.
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, bram_wea=0, FSM=IDLE, all pending flags cleared.
- Reset asserted mid-transfer discards a pending write; no partial RAM write occurs after reset deasserts.

Optional Feature:
BRAM_FWD_EN
- Defined:
  - No collision stall; RD_STALL is unused.
  - On collision the block registers HWDATA and the write mask alongside the read.
  - In the read data phase, HRDATA = per-byte merge: masked bytes come from the forwarded write data, the rest from bram_doutb.
  - Reads are always zero-wait.
- Undefined: one-wait-state stall as described in Behaviour.

Decomposition:
- Package ahb_bram_pkg:
  - HTRANS codes (IDLE/BUSY/NONSEQ/SEQ)
  - HSIZE codes
  - HRESP codes
  - FSM state encoding
  - word-offset constant 2
- Sub-module ahb_bram_bytemask: combinational HSIZE/HADDR[1:0] -> 4-bit mask plus illegal flag. Used once; keeps the size-decode rules testable in isolation.

Test Plan:
1. Reset with HRESETn=0 mid-write-data-phase -> bram_wea=0 immediately, HREADYOUT=1, HRESP=0, HRDATA=0; RAM word unchanged.
2. Word write 0xDEADBEEF to 0x10, then non-adjacent read of 0x10 -> bram_wea=1111 at addra=4 in the data phase; read returns 0xDEADBEEF with zero wait.
3. Byte write 0xAA at 0x13, halfword write 0x5566 at 0x10 -> wea=1000 then 0011; subsequent read of 0x10 = 0xAAxx5566 (xx = prior byte).
4. Write word 0x11223344 to 0x20 immediately followed by a read of 0x20 -> without BRAM_FWD_EN: one cycle HREADYOUT=0, then HRDATA=0x11223344. With it: zero wait, HRDATA=0x11223344.
5. Same back-to-back pattern but read 0x24 -> no stall; HRDATA = contents of word 9.
6. Halfword write at 0x01, and HSIZE=3 read -> two-cycle ERROR (HREADYOUT 0 then 1, HRESP=1 both cycles), bram_wea stays 0000.
